// File: rtl/key_player_pkg.sv
// Shared definitions for the key player/recorder: state encoding and default key geometry.
package key_player_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam int unsigned DEF_NUM_KEYS = 12;
   localparam int unsigned DEF_KEY_W    = 4;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StHold = ST_HOLD,
      StGap  = ST_GAP
   } state_e;

endpackage

// File: rtl/key_onehot_decoder.sv
// Key index to one-hot decoder; rest or an index past the last key yields all zeros.
module key_onehot_decoder #(
   parameter int unsigned NUM_KEYS = 12,
   parameter int unsigned KEY_W    = 4
) (
   input  logic [KEY_W-1:0]    idx,
   input  logic                rest,
   output logic [NUM_KEYS-1:0] onehot
);

   // Comparing against every legal key doubles as the range check.
   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         onehot[i] = !rest && (32'(idx) == i);
      end
   end

endmodule

// File: rtl/key_event_player.sv
// Replays timed key events as active/press/release vectors matching the debounced live keys.
// Optional NOTE_COUNT_EN adds a saturating count of press cycles on note_count.
module key_event_player
   import key_player_pkg::*;
#(
   parameter int unsigned NUM_KEYS   = DEF_NUM_KEYS,
   parameter int unsigned KEY_W      = DEF_KEY_W,
   parameter int unsigned DUR_W      = 8,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                slow_clk,
   input  logic                rst_n,
   input  logic                ev_valid,
   output logic                ev_ready,
   input  logic [KEY_W-1:0]    ev_key,
   input  logic                ev_rest,
   input  logic [DUR_W-1:0]    ev_dur,
   input  logic                abort,
   output logic [NUM_KEYS-1:0] key_active,
   output logic [NUM_KEYS-1:0] key_posedge,
   output logic [NUM_KEYS-1:0] key_negedge,
   output logic                busy
`ifdef NOTE_COUNT_EN
   ,
   output logic [15:0]         note_count
`endif
);

   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

   state_e                state;
   logic [KEY_W-1:0]      key_q;
   logic                  rest_q;
   logic [DUR_W-1:0]      dur_cnt;
   logic [GAP_W-1:0]      gap_cnt;
   logic [KEY_W-1:0]      dec_idx;
   logic                  dec_rest;
   logic [NUM_KEYS-1:0]   dec_onehot;
   logic                  accept;

   assign ev_ready = (state == StIdle) & ~abort;
   assign accept   = ev_valid & ev_ready;

   // In IDLE decode the offered event (press); afterwards the latched one (release).
   assign dec_idx  = (state == StIdle) ? ev_key  : key_q;
   assign dec_rest = (state == StIdle) ? ev_rest : rest_q;

   key_onehot_decoder #(
      .NUM_KEYS (NUM_KEYS),
      .KEY_W    (KEY_W)
   ) u_dec (
      .idx    (dec_idx),
      .rest   (dec_rest),
      .onehot (dec_onehot)
   );

   always_ff @(posedge slow_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         key_q       <= '0;
         rest_q      <= 1'b0;
         dur_cnt     <= '0;
         gap_cnt     <= '0;
         key_active  <= '0;
         key_posedge <= '0;
         key_negedge <= '0;
         busy        <= 1'b0;
      end else begin
         key_posedge <= '0;
         key_negedge <= '0;
         unique case (state)
            StIdle: begin
               if (accept) begin
                  key_q       <= ev_key;
                  rest_q      <= ev_rest;
                  dur_cnt     <= (ev_dur == '0) ? DUR_W'(1) : ev_dur;
                  key_active  <= dec_onehot;
                  key_posedge <= dec_onehot;
                  busy        <= 1'b1;
                  state       <= StHold;
               end
            end
            StHold: begin
               if (abort || dur_cnt <= DUR_W'(1)) begin
                  key_active  <= '0;
                  key_negedge <= dec_onehot;
                  dur_cnt     <= '0;
                  gap_cnt     <= GAP_W'(GAP_CYCLES);
                  state       <= StGap;
               end else begin
                  dur_cnt <= dur_cnt - DUR_W'(1);
               end
            end
            StGap: begin
               if (gap_cnt <= GAP_W'(1)) begin
                  gap_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= StIdle;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               key_active <= '0;
               busy       <= 1'b0;
               state      <= StIdle;
            end
         endcase
      end
   end

`ifdef NOTE_COUNT_EN
   always_ff @(posedge slow_clk or negedge rst_n) begin
      if (!rst_n) begin
         note_count <= '0;
      end else if (|key_posedge && note_count != 16'hFFFF) begin
         note_count <= note_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_key_event_player.sv
// Scoreboard bench for key_event_player: the driver queues expected per-cycle frames, a monitor checks them.
module tb_key_event_player;

   localparam int unsigned NK = 12;
   localparam int unsigned KW = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned G  = 2;

   logic          slow_clk = 1'b0;
   logic          rst_n    = 1'b0;
   logic          ev_valid = 1'b0;
   logic          ev_rest  = 1'b0;
   logic          abort    = 1'b0;
   logic [KW-1:0] ev_key   = '0;
   logic [DW-1:0] ev_dur   = '0;
   logic          ev_ready;
   logic          busy;
   logic [NK-1:0] key_active;
   logic [NK-1:0] key_posedge;
   logic [NK-1:0] key_negedge;
`ifdef NOTE_COUNT_EN
   logic [15:0]   note_count;
`endif

   always #5 slow_clk = ~slow_clk;

   key_event_player #(
      .NUM_KEYS   (NK),
      .KEY_W      (KW),
      .DUR_W      (DW),
      .GAP_CYCLES (G)
   ) dut (
      .slow_clk    (slow_clk),
      .rst_n       (rst_n),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_key      (ev_key),
      .ev_rest     (ev_rest),
      .ev_dur      (ev_dur),
      .abort       (abort),
      .key_active  (key_active),
      .key_posedge (key_posedge),
      .key_negedge (key_negedge),
`ifdef NOTE_COUNT_EN
      .note_count  (note_count),
`endif
      .busy        (busy)
   );

   typedef struct packed {
      logic [NK-1:0] act;
      logic [NK-1:0] pos;
      logic [NK-1:0] neg;
      logic          busy;
      logic          ready;
   } frame_t;

   frame_t sb[$];
   int     n_vec = 0;
   int     n_err = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s at %0t: bound expired", name, $time);
   endtask

   // Monitor: one expected frame per cycle while the scoreboard holds any.
   initial begin
      forever begin
         @(negedge slow_clk);
         #1;
         if (sb.size() > 0) begin
            frame_t f;
            f = sb.pop_front();
            chk("key_active",  16'(key_active),  16'(f.act));
            chk("key_posedge", 16'(key_posedge), 16'(f.pos));
            chk("key_negedge", 16'(key_negedge), 16'(f.neg));
            chk("busy",        16'(busy),        16'(f.busy));
            chk("ev_ready",    16'(ev_ready),    16'(f.ready));
         end
      end
   end

   // Expected frames for cycles T+1.. after a handshake at T; a = abort offset (0 = none).
   function automatic int push_event(input int k, input bit r, input int d, input int a,
                                     input int lim);
      logic [NK-1:0] oh;
      frame_t        f;
      int            dd, h, n;
      oh = (r || k >= int'(NK)) ? '0 : (NK'(1) << k);
      dd = (d == 0) ? 1 : d;
      h  = (a != 0 && a < dd) ? a : dd;
      n  = 0;
      for (int off = 1; off <= h + int'(G) + 1; off++) begin
         if (lim != 0 && n >= lim) break;
         f.act   = (off <= h) ? oh : '0;
         f.pos   = (off == 1) ? oh : '0;
         f.neg   = (off == h + 1) ? oh : '0;
         f.busy  = (off <= h + int'(G));
         f.ready = (off == h + int'(G) + 1);
         sb.push_back(f);
         n++;
      end
      return h;
   endfunction

   task automatic offer(input int k, input bit r, input int d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge slow_clk);
         ev_valid = 1'b1;
         ev_key   = KW'(k);
         ev_rest  = r;
         ev_dur   = DW'(d);
         #1 ok = ev_ready;
      end
      if (!ok) begin
         fail_now("handshake_wait");
         ev_valid = 1'b0;
      end else begin
         @(posedge slow_clk);
      end
   endtask

   task automatic send(input int k, input bit r, input int d, input int a);
      bit ok;
      int h;
      offer(k, r, d, ok);
      if (ok) begin
         h = push_event(k, r, d, a, 0);
         for (int off = 1; off <= h + 1; off++) begin
            @(negedge slow_clk);
            if (off == 1) begin
               // Scramble the fields after acceptance; the DUT must ignore them.
               ev_valid = 1'b0;
               ev_key   = 4'd9;
               ev_dur   = 8'd1;
               ev_rest  = 1'b1;
            end
            abort = (a != 0 && off == a);
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge slow_clk);
      if (sb.size() > 0) begin
         fail_now("scoreboard_drain");
         sb.delete();
      end
   endtask

   initial begin
      bit ok;
      int h;
      repeat (3) @(posedge slow_clk);
      @(negedge slow_clk);
      rst_n = 1'b1;
      #1;
      chk("rst_active",  16'(key_active),  16'h0);
      chk("rst_posedge", 16'(key_posedge), 16'h0);
      chk("rst_negedge", 16'(key_negedge), 16'h0);
      chk("rst_busy",    16'(busy),        16'h0);
      chk("rst_ready",   16'(ev_ready),    16'h1);
`ifdef NOTE_COUNT_EN
      chk("rst_note_count", note_count, 16'h0);
`endif

      send(3, 1'b0, 4, 0);
      drain();
      send(0, 1'b0, 0, 0);
      send(0, 1'b0, 1, 0);
      drain();
      send(0, 1'b1, 5, 0);
      drain();
      send(13, 1'b0, 5, 0);
      drain();
      send(5, 1'b0, 10, 3);
      drain();
      send(8, 1'b0, 3, 1);
      drain();

      // Abort held in IDLE blocks acceptance.
      @(negedge slow_clk);
      abort    = 1'b1;
      ev_valid = 1'b1;
      ev_key   = 4'd2;
      ev_rest  = 1'b0;
      ev_dur   = 8'd3;
      #1 chk("idle_abort_ready", 16'(ev_ready), 16'h0);
      @(negedge slow_clk);
      #1;
      chk("idle_abort_busy",   16'(busy),       16'h0);
      chk("idle_abort_active", 16'(key_active), 16'h0);
      abort    = 1'b0;
      ev_valid = 1'b0;

      // Reset in the middle of a hold clears everything with no release pulse.
      offer(7, 1'b0, 8, ok);
      if (ok) begin
         h = push_event(7, 1'b0, 8, 0, 2);
         @(negedge slow_clk);
         ev_valid = 1'b0;
         @(negedge slow_clk);
         #2 rst_n = 1'b0;
         #1;
         chk("midrst_active",  16'(key_active),  16'h0);
         chk("midrst_posedge", 16'(key_posedge), 16'h0);
         chk("midrst_negedge", 16'(key_negedge), 16'h0);
         chk("midrst_busy",    16'(busy),        16'h0);
         @(posedge slow_clk);
         @(negedge slow_clk);
         rst_n = 1'b1;
         @(negedge slow_clk);
         #1;
         chk("postrst_negedge", 16'(key_negedge), 16'h0);
         chk("postrst_active",  16'(key_active),  16'h0);
         chk("postrst_ready",   16'(ev_ready),    16'h1);
      end
      drain();

      send(1, 1'b0, 2, 0);
      send(2, 1'b0, 1, 0);
      send(11, 1'b0, 255, 0);
      send(4, 1'b1, 3, 0);
      drain();
`ifdef NOTE_COUNT_EN
      chk("note_count", note_count, 16'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/key_event_player.md
Name: key_event_player

Overview:
Playback-side generator for the key-state interface. It accepts timed key events (key index, duration) over a valid/ready handshake and drives a per-key active vector plus one-cycle press/release pulses. Timing and pulse semantics match the debounced live-key outputs, so downstream tone logic cannot tell replayed keys from played ones. It sits between the recording memory reader and the tone generator mux, clocked on the slow (key-sampling) clock.

Parameters:
NUM_KEYS, 12, number of keys driven; also the width of the output vectors.
KEY_W, 4, width of the key index; must satisfy 2^KEY_W >= NUM_KEYS.
DUR_W, 8, width of the duration field, in slow_clk cycles.
GAP_CYCLES, 2, all-keys-low cycles after each event, counting the release cycle; must be >= 1.

Ports:
slow_clk  in  1  sole clock, key-sampling rate
rst_n  in  1  asynchronous active-low reset
ev_valid  in  1  event offered
ev_ready  out  1  event accepted when high together with ev_valid
ev_key  in  KEY_W  key index; values >= NUM_KEYS mean rest
ev_rest  in  1  1 = rest event (silence for ev_dur cycles)
ev_dur  in  DUR_W  hold length in cycles; 0 is treated as 1
abort  in  1  synchronous cut of the current event
key_active  out  NUM_KEYS  level: key held
key_posedge  out  NUM_KEYS  one-cycle press pulse
key_negedge  out  NUM_KEYS  one-cycle release pulse
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; key_active, key_posedge and key_negedge are all 0; busy 0; counters 0. ev_ready follows from IDLE (1 when abort is low).
- All outputs except ev_ready are registered. ev_ready = (state==IDLE) & ~abort, combinational.
- FSM states: IDLE, HOLD, GAP.
- IDLE: on handshake at cycle T:
  - latch key index, rest flag and D = max(ev_dur,1);
  - load the duration counter; go to HOLD.
  - A key index >= NUM_KEYS forces rest.
- HOLD, key event:
  - key_active[k]=1 during T+1..T+D.
  - key_posedge[k]=1 in T+1 only.
  - No other bit is ever set.
- HOLD, rest event: all outputs 0 for T+1..T+D.
- End of HOLD: at T+D+1, key_active=0 and key_negedge[k]=1 for one cycle (rest: no pulse). Enter GAP.
- GAP: lasts GAP_CYCLES cycles, T+D+1..T+D+GAP_CYCLES. ev_ready rises at T+D+GAP_CYCLES+1.
- Back-to-back events on the same key always produce a distinct negedge, at least one low cycle, then a new posedge.
- Duration counter: DUR_W-bit down-counter, no wrap. The maximum D = 2^DUR_W-1 holds exactly that many cycles.
- Abort:
  - Sampled each cycle.
  - In HOLD, abort at cycle A: release at A+1 (negedge pulse if key event), GAP from A+1, ev_ready at A+GAP_CYCLES+1.
  - In GAP: no effect.
  - In IDLE: blocks acceptance, because ev_ready is low.
  - Abort at T+1, the same cycle posedge is shown: valid; negedge follows at T+2.
- Inputs ev_key, ev_rest and ev_dur are only sampled at the handshake. Changes afterward are ignored.
- Reset mid-HOLD: outputs clear immediately. No negedge pulse is emitted; consumers treat reset as a global release.

Optional Feature:
NOTE_COUNT_EN
- Defined: adds output note_count [15:0].
  - Increments on every cycle in which any key_posedge bit is 1.
  - Saturates at 16'hFFFF.
  - Reset value 0; not cleared by abort.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package/header key_player_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_HOLD=2'd1, ST_GAP=2'd2;
  - default NUM_KEYS/KEY_W constants, shared with the recorder.
- One sub-module, key_onehot_decoder: combinational index -> NUM_KEYS one-hot with range check. Out-of-range or rest gives all zeros. It is used to build the posedge, active and negedge vectors.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> all vectors 0, busy=0, ev_ready=1.
- key=3, dur=4, gap=2, handshake at T -> active[3] high T+1..T+4; posedge[3] at T+1; negedge[3] at T+5; ev_ready high at T+7; no other bits set.
- dur=0 on key=0 -> active[0] high for exactly 1 cycle (T+1); negedge at T+2. Then key=0 dur=1 offered immediately -> one low cycle minimum, new posedge at T+5.
- Rest cases -> no outputs toggle, busy=1, ev_ready high at T+D+GAP_CYCLES+1:
  - rest=1, dur=5: ev_ready at T+8;
  - key=13 (out of range), dur=5: same result.
- key=5, dur=10, abort at T+3 -> negedge[5] at T+4, active[5] low from T+4, ev_ready at T+6. Abort held high in IDLE -> ev_ready=0 and no accept.
- Two more cases:
  - rst_n pulsed low at T+2 of key=7 dur=8 -> active clears asynchronously with no negedge pulse.
  - With NOTE_COUNT_EN defined: 3 key events plus 1 rest -> note_count=3.
